interp_tile_walker: RTL

- Drives the PVR plane-equation interpolator from its input side and drains its output.
- Accepts one triangle/tile job per handshake and pulses the interpolator's setup strobe while vertex coefficients are stable.
- Waits for the plane coefficients to settle, then scans a square tile in row-major order, presenting pixel coordinates and capturing each interpolated value.
- Emits a backpressured pixel stream toward the depth/shading stage.

---
 rtl/interp_tile_walker.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/interp_tile_walker.sv
// Tile walker for the plane-equation interpolator. It accepts a tile job, pulses setup and waits
// for the coefficients to settle, then scans the tile row-major into a backpressured pixel stream.
module interp_tile_walker #(
    parameter int TILE_LOG2  = 5,
    parameter int SETUP_WAIT = 1,
    parameter int DATA_W     = 32
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        tri_valid_i,
    output logic                        tri_ready_o,
    input  logic [4:0]                  tile_x_i,
    input  logic [4:0]                  tile_y_i,
    output logic                        ip_setup_o,
    output logic signed [TILE_LOG2+5:0] ip_x_ps_o,
    output logic signed [TILE_LOG2+5:0] ip_y_ps_o,
    input  logic signed [DATA_W-1:0]    ip_value_i,
    output logic                        px_valid_o,
    input  logic                        px_ready_i,
    output logic [TILE_LOG2-1:0]        px_x_o,
    output logic [TILE_LOG2-1:0]        px_y_o,
    output logic signed [DATA_W-1:0]    px_value_o,
    output logic                        px_first_o,
    output logic                        px_last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WALK,
        S_DRAIN
    } state_t;

    localparam logic [TILE_LOG2-1:0] CMAX      = '1;
    localparam logic [3:0]           WAIT_INIT = 4'(SETUP_WAIT);

    state_t                     state_q, state_d;
    logic [TILE_LOG2-1:0]       cx_q, cx_d;
    logic [TILE_LOG2-1:0]       cy_q, cy_d;
    logic [3:0]                 wait_q, wait_d;
    logic [4:0]                 tile_x_q, tile_x_d;
    logic [4:0]                 tile_y_q, tile_y_d;
    logic                       px_valid_q, px_valid_d;
    logic [TILE_LOG2-1:0]       px_x_q, px_x_d;
    logic [TILE_LOG2-1:0]       px_y_q, px_y_d;
    logic signed [DATA_W-1:0]   px_value_q, px_value_d;
    logic                       px_first_q, px_first_d;
    logic                       px_last_q, px_last_d;
    logic                       done_q, done_d;
    logic                       load;
    logic                       at_end;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            wait_q     <= '0;
            tile_x_q   <= '0;
            tile_y_q   <= '0;
            px_valid_q <= 1'b0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            px_value_q <= '0;
            px_first_q <= 1'b0;
            px_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            wait_q     <= wait_d;
            tile_x_q   <= tile_x_d;
            tile_y_q   <= tile_y_d;
            px_valid_q <= px_valid_d;
            px_x_q     <= px_x_d;
            px_y_q     <= px_y_d;
            px_value_q <= px_value_d;
            px_first_q <= px_first_d;
            px_last_q  <= px_last_d;
            done_q     <= done_d;
        end
    end

    // A load fills the output slot whenever it is empty or being drained this cycle.
    assign load   = (state_q == S_WALK) && (!px_valid_q || px_ready_i);
    assign at_end = (cx_q == CMAX) && (cy_q == CMAX);

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        wait_d     = wait_q;
        tile_x_d   = tile_x_q;
        tile_y_d   = tile_y_q;
        px_valid_d = px_valid_q;
        px_x_d     = px_x_q;
        px_y_d     = px_y_q;
        px_value_d = px_value_q;
        px_first_d = px_first_q;
        px_last_d  = px_last_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tri_valid_i) begin
                    tile_x_d = tile_x_i;
                    tile_y_d = tile_y_i;
                    cx_d     = '0;
                    cy_d     = '0;
                    wait_d   = WAIT_INIT;
                    state_d  = (WAIT_INIT == 4'd0) ? S_WALK : S_WAIT;
                end
            end
            S_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q <= 4'd1) begin
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (load) begin
                    px_value_d = ip_value_i;
                    px_x_d     = cx_q;
                    px_y_d     = cy_q;
                    px_first_d = (cx_q == '0) && (cy_q == '0);
                    px_last_d  = at_end;
                    px_valid_d = 1'b1;
                    // The final pixel parks the counters at (max,max) instead of wrapping.
                    if (at_end) begin
                        state_d = S_DRAIN;
                    end else begin
                        cx_d = cx_q + 1'b1;
                        if (cx_q == CMAX) begin
                            cy_d = cy_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (px_ready_i) begin
                    px_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tri_ready_o = (state_q == S_IDLE);
    assign ip_setup_o  = tri_valid_i && tri_ready_o;
    assign busy_o      = (state_q != S_IDLE);
    assign ip_x_ps_o   = {1'b0, tile_x_q, cx_q};
    assign ip_y_ps_o   = {1'b0, tile_y_q, cy_q};
    assign px_valid_o  = px_valid_q;
    assign px_x_o      = px_x_q;
    assign px_y_o      = px_y_q;
    assign px_value_o  = px_value_q;
    assign px_first_o  = px_first_q;
    assign px_last_o   = px_last_q;
    assign done_o      = done_q;

endmodule
